// File: rtl/pl_sysref_capture_ctrl.sv
// pl_sysref_capture_ctrl
// Synchronises the buffered PL SYSREF, measures its period to declare lock and,
// once armed by software, forwards whole SYSREF pulses to the RFDC user_sysref inputs.
module pl_sysref_capture_ctrl #(
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned PERIOD_W    = 16,
   parameter int unsigned LOCK_COUNT  = 4
) (
   input  logic                pl_clk,
   input  logic                pl_resetn,
   input  logic                pl_sysref,
   input  logic                arm,
   input  logic                disarm,
   input  logic                mode,
   input  logic [NUM_CH-1:0]   ch_en,
   input  logic                err_clear,
   output logic [NUM_CH-1:0]   sysref_out,
   output logic                locked,
   output logic [PERIOD_W-1:0] period,
   output logic                period_err,
   output logic                busy,
   output logic                done
);

   localparam int unsigned         MATCH_W   = 8;
   localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
   localparam logic [MATCH_W-1:0]  MATCH_MAX = MATCH_W'(LOCK_COUNT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_FWD   = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   s_d;
   logic                   rise_c;
   logic                   fall_c;

   logic [PERIOD_W-1:0]    cnt;
   logic [PERIOD_W-1:0]    cnt_nxt_c;
   logic [PERIOD_W-1:0]    prev;
   logic [PERIOD_W-1:0]    meas_c;
   logic                   meas_valid_c;
   logic [MATCH_W-1:0]     match;
   logic [MATCH_W-1:0]     match_nxt_c;
   logic                   locked_nxt_c;

   state_t                 state;
   state_t                 state_nxt_c;
   logic                   mode_lat;
   logic [NUM_CH-1:0]      ch_en_lat;
   logic                   stop_pend;
   logic                   arm_ok_c;
   logic                   fwd_c;
   logic                   done_nxt_c;
   logic                   stop_set_c;

   assign s      = sync_q[SYNC_STAGES-1];
   assign rise_c = s & ~s_d;
   assign fall_c = ~s & s_d;

   // Metastability synchroniser on the SYSREF pin plus one-cycle delayed copy for edge detect
   always_ff @(posedge pl_clk or negedge pl_resetn) begin
      if (!pl_resetn) begin
         sync_q <= '0;
         s_d    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pl_sysref};
         s_d    <= s;
      end
   end

   // Period measurement and consecutive-match tracking; lock drops when the counter saturates
   always_comb begin
      cnt_nxt_c    = cnt;
      match_nxt_c  = match;
      meas_c       = cnt + PERIOD_W'(1);
      meas_valid_c = rise_c && (cnt != CNT_MAX);
      if (rise_c) begin
         cnt_nxt_c = '0;
      end else if (cnt != CNT_MAX) begin
         cnt_nxt_c = cnt + PERIOD_W'(1);
      end
      if (rise_c) begin
         if (meas_valid_c && (meas_c == prev)) begin
            if (match != MATCH_MAX) begin
               match_nxt_c = match + MATCH_W'(1);
            end
         end else begin
            match_nxt_c = '0;
         end
      end else if (cnt_nxt_c == CNT_MAX) begin
         match_nxt_c = '0;
      end
      locked_nxt_c = (match_nxt_c == MATCH_MAX);
   end

   // Lock state registers; a falling lock sets the sticky error, which beats a clear
   always_ff @(posedge pl_clk or negedge pl_resetn) begin
      if (!pl_resetn) begin
         cnt        <= CNT_MAX;
         prev       <= '0;
         match      <= '0;
         locked     <= 1'b0;
         period     <= '0;
         period_err <= 1'b0;
      end else begin
         cnt    <= cnt_nxt_c;
         match  <= match_nxt_c;
         locked <= locked_nxt_c;
         if (meas_valid_c) begin
            prev   <= meas_c;
            period <= meas_c;
         end
         if (locked && !locked_nxt_c) begin
            period_err <= 1'b1;
         end else if (err_clear) begin
            period_err <= 1'b0;
         end
      end
   end

   // Capture FSM state register
   always_ff @(posedge pl_clk or negedge pl_resetn) begin
      if (!pl_resetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt_c;
      end
   end

   // Capture FSM next state; exits from FWD only happen while the synchronised level is low
   always_comb begin
      state_nxt_c = state;
      case (state)
         S_IDLE: begin
            if (arm && !disarm) begin
               state_nxt_c = S_ARMED;
            end
         end
         S_ARMED: begin
            if (disarm) begin
               state_nxt_c = S_IDLE;
            end else if (rise_c && locked) begin
               state_nxt_c = S_FWD;
            end
         end
         S_FWD: begin
            if (!mode_lat) begin
               if (fall_c) begin
                  state_nxt_c = S_IDLE;
               end
            end else if (!s && (disarm || stop_pend)) begin
               state_nxt_c = S_IDLE;
            end
         end
         default: state_nxt_c = S_IDLE;
      endcase
   end

   // Capture FSM decoded controls; a disarm in ARMED wins so no partial pulse leaks out
   always_comb begin
      arm_ok_c   = (state == S_IDLE) && arm && !disarm;
      fwd_c      = (state == S_FWD) ||
                   ((state == S_ARMED) && rise_c && locked && !disarm);
      done_nxt_c = (state == S_FWD) && !mode_lat && fall_c;
      stop_set_c = (state == S_FWD) && mode_lat && disarm && s;
   end

   // Arm-time configuration latch and deferred stop request for continuous mode
   always_ff @(posedge pl_clk or negedge pl_resetn) begin
      if (!pl_resetn) begin
         mode_lat  <= 1'b0;
         ch_en_lat <= '0;
         stop_pend <= 1'b0;
      end else begin
         if (arm_ok_c) begin
            mode_lat  <= mode;
            ch_en_lat <= ch_en;
         end
         if (state_nxt_c != S_FWD) begin
            stop_pend <= 1'b0;
         end else if (stop_set_c) begin
            stop_pend <= 1'b1;
         end
      end
   end

   // Registered gated SYSREF outputs and status
   always_ff @(posedge pl_clk or negedge pl_resetn) begin
      if (!pl_resetn) begin
         sysref_out <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         sysref_out <= fwd_c ? ({NUM_CH{s}} & ch_en_lat) : '0;
         busy       <= (state_nxt_c != S_IDLE);
         done       <= done_nxt_c;
      end
   end

endmodule

// File: tb/tb_pl_sysref_capture_ctrl.sv
// Randomised bench for pl_sysref_capture_ctrl: a timestamp-based reference model
// pushes the expected output bundle each cycle, a monitor pops and compares.
module tb_pl_sysref_capture_ctrl;

   localparam int unsigned NUM_CH      = 2;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned PERIOD_W    = 16;
   localparam int unsigned LOCK_COUNT  = 4;
   localparam int          SS          = int'(SYNC_STAGES);
   localparam int          MAX_CYC     = 90000;
   localparam int          SAT_GAP     = 65535;

   logic                pl_clk     = 1'b0;
   logic                pl_resetn  = 1'b0;
   logic                pl_sysref  = 1'b0;
   logic                arm        = 1'b0;
   logic                disarm     = 1'b0;
   logic                mode       = 1'b0;
   logic [NUM_CH-1:0]   ch_en      = '0;
   logic                err_clear  = 1'b0;
   logic [NUM_CH-1:0]   sysref_out;
   logic                locked;
   logic [PERIOD_W-1:0] period;
   logic                period_err;
   logic                busy;
   logic                done;

   pl_sysref_capture_ctrl #(
      .NUM_CH      (NUM_CH),
      .SYNC_STAGES (SYNC_STAGES),
      .PERIOD_W    (PERIOD_W),
      .LOCK_COUNT  (LOCK_COUNT)
   ) dut (
      .pl_clk     (pl_clk),
      .pl_resetn  (pl_resetn),
      .pl_sysref  (pl_sysref),
      .arm        (arm),
      .disarm     (disarm),
      .mode       (mode),
      .ch_en      (ch_en),
      .err_clear  (err_clear),
      .sysref_out (sysref_out),
      .locked     (locked),
      .period     (period),
      .period_err (period_err),
      .busy       (busy),
      .done       (done)
   );

   always #5 pl_clk = ~pl_clk;

   typedef struct packed {
      logic [NUM_CH-1:0]   so;
      logic                lk;
      logic [PERIOD_W-1:0] per;
      logic                err;
      logic                bz;
      logic                dn;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // ---------------- reference model ----------------
   bit                  pin_hist[MAX_CYC];
   int                  cyc      = 0;
   int                  rst_rel  = 1 << 30;
   int                  last_rise;
   int                  prev_meas;
   int unsigned         m_match;
   logic                m_locked;
   logic [PERIOD_W-1:0] m_period;
   logic                m_err;
   bit                  armed, fwd_on, one_shot, stop_req;
   logic [NUM_CH-1:0]   mask;

   // synchronised pin level seen by the design in cycle m (zero before reset release)
   function automatic bit s_at(input int m);
      if (m - SS >= rst_rel) return pin_hist[m - SS];
      return 1'b0;
   endfunction

   initial begin
      bit   s, sd, rise, fall, lk_prev, fwd_now, valid;
      int   gap;
      obs_t e;
      forever begin
         @(posedge pl_clk);
         cyc++;
         if (cyc < MAX_CYC) pin_hist[cyc] = pl_sysref;
         if (!pl_resetn) begin
            rst_rel   = cyc + 1;
            last_rise = -1;
            prev_meas = 0;
            m_match   = 0;
            m_locked  = 1'b0;
            m_period  = '0;
            m_err     = 1'b0;
            armed     = 0;
            fwd_on    = 0;
            one_shot  = 0;
            stop_req  = 0;
            mask      = '0;
            exp_q.push_back('0);
         end else begin
            s       = s_at(cyc);
            sd      = s_at(cyc - 1);
            rise    = s && !sd;
            fall    = !s && sd;
            lk_prev = m_locked;
            // lock: count rises whose spacing repeats; silence of 65535 cycles drops it
            if (rise) begin
               gap   = cyc - last_rise;
               valid = (last_rise >= 0) && (gap <= SAT_GAP);
               if (valid) begin
                  if (gap == prev_meas) begin
                     if (m_match < LOCK_COUNT) m_match++;
                  end else begin
                     m_match = 0;
                  end
                  prev_meas = gap;
                  m_period  = PERIOD_W'(gap);
               end else begin
                  m_match = 0;
               end
               last_rise = cyc;
            end else if (last_rise < 0 || (cyc - last_rise) >= SAT_GAP) begin
               m_match = 0;
            end
            m_locked = (m_match == LOCK_COUNT);
            m_err    = (lk_prev && !m_locked) || (m_err && !err_clear);
            // capture session
            fwd_now = fwd_on || (armed && rise && lk_prev && !disarm);
            e.so    = (fwd_now && s) ? mask : '0;
            e.dn    = fwd_on && one_shot && fall;
            if (fwd_on) begin
               if (one_shot) begin
                  if (fall) fwd_on = 0;
               end else if (!s && (disarm || stop_req)) begin
                  fwd_on = 0;
               end else if (disarm) begin
                  stop_req = 1;
               end
            end else if (armed) begin
               if (disarm) begin
                  armed = 0;
               end else if (rise && lk_prev) begin
                  armed    = 0;
                  fwd_on   = 1;
                  stop_req = 0;
               end
            end else if (arm && !disarm) begin
               armed    = 1;
               one_shot = !mode;
               mask     = ch_en;
            end
            e.lk  = m_locked;
            e.per = m_period;
            e.err = m_err;
            e.bz  = armed || fwd_on;
            exp_q.push_back(e);
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      obs_t e;
      obs_t a;
      forever begin
         @(negedge pl_clk);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty t=%0t: no expected entry", $time);
         end else begin
            e = exp_q.pop_front();
            if (!pl_resetn) e = '0;
            a = {sysref_out, locked, period, period_err, busy, done};
            if (a !== e) begin
               errors++;
               $display("FAIL outputs cyc=%0d got so=%b lk=%b per=%0d err=%b bz=%b dn=%b exp so=%b lk=%b per=%0d err=%b bz=%b dn=%b",
                        cyc, a.so, a.lk, a.per, a.err, a.bz, a.dn,
                        e.so, e.lk, e.per, e.err, e.bz, e.dn);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   int          per_len = 32;
   int          hi_len  = 8;
   int          ph      = 0;
   bit          pin_on  = 1;
   int unsigned arm_pm  = 0;
   int unsigned dis_pm  = 0;
   int unsigned clr_pm  = 0;

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge pl_clk);
         #1;
         pl_sysref = pin_on && (ph < hi_len);
         ph        = (ph + 1 >= per_len) ? 0 : ph + 1;
         arm       = ($urandom_range(0, 999) < arm_pm);
         disarm    = ($urandom_range(0, 999) < dis_pm);
         err_clear = ($urandom_range(0, 999) < clr_pm);
         mode      = 1'($urandom_range(0, 1));
         ch_en     = NUM_CH'($urandom);
      end
   endtask

   initial begin
      // reset held while the pin toggles
      run(20);
      pl_resetn = 1'b1;
      // arming before lock is reached
      arm_pm = 20; dis_pm = 2;
      run(150);
      // random arm / disarm / clear traffic on a stable 32-cycle SYSREF
      arm_pm = 20; dis_pm = 10; clr_pm = 5;
      run(3000);
      // period step to 33 and back
      per_len = 33;
      run(400);
      per_len = 32;
      run(1200);
      // random period jitter with a wider pulse
      for (int k = 0; k < 6; k++) begin
         per_len = 31 + int'($urandom_range(0, 2));
         hi_len  = 6 + int'($urandom_range(0, 6));
         run(200);
      end
      per_len = 32; hi_len = 8;
      run(500);
      // reset in the middle of activity
      arm_pm = 40;
      run(300);
      pl_resetn = 1'b0;
      run(3);
      pl_resetn = 1'b1;
      run(800);
      // SYSREF stops: lock must fall on counter saturation and the error must stick
      pin_on = 0; arm_pm = 5; dis_pm = 0; clr_pm = 0;
      run(65700);
      clr_pm = 50;
      run(100);
      arm = 1'b0; disarm = 1'b0; err_clear = 1'b0;
      @(negedge pl_clk);
      @(negedge pl_clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
